// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and sizing helpers.
package muldiv_pkg;

    localparam int unsigned ITERS_DEFAULT = 32;

    function automatic int unsigned cnt_width(input int unsigned iters);
        return $clog2(iters) + 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(ITERS_DEFAULT);

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return !op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply, restoring
// subtract-compare for divide (partial remainder held in acc_hi).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = ITERS_DEFAULT
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0] addend;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        addend  = acc_lo[0] ? {1'b0, opnd} : '0;
        sum     = {1'b0, acc_hi} + addend;
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        if (is_div) begin
            // diff[WIDTH] set means the trial subtraction went negative: restore
            nxt_hi = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO. Optional MULDIV_EARLY_OUT_EN
// completes divide-by-zero and zero-operand multiplies in one busy cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = ITERS_DEFAULT,
    parameter int unsigned ITERS = WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = cnt_width(ITERS);
    localparam int unsigned PW = 2 * WIDTH;

    state_e           state;
    logic [CW-1:0]    cnt;
    logic             is_div_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic             div0_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    logic             is_div_in;
    logic             sgn_in;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;

    // Operand magnitudes and sign flags for a request presented in IDLE
    always_comb begin
        is_div_in = op_is_div(op);
        sgn_in    = op_is_signed(op);
        a_neg     = sgn_in & in1[WIDTH-1];
        b_neg     = sgn_in & in2[WIDTH-1];
        mag1      = a_neg ? (~in1 + WIDTH'(1)) : in1;
        mag2      = b_neg ? (~in2 + WIDTH'(1)) : in2;
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic early;
    assign early = is_div_in ? (in2 == '0) : ((in1 == '0) || (in2 == '0));
`endif

    logic [PW-1:0]    prod;
    logic [PW-1:0]    prod_s;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    // Sign fix-up; with a zero divisor the remainder path already yields raw in1
    always_comb begin
        prod   = {acc_hi, acc_lo};
        prod_s = neg_res_q ? (~prod + PW'(1)) : prod;
        quo_s  = neg_res_q ? (~acc_lo + WIDTH'(1)) : acc_lo;
        rem_s  = neg_rem_q ? (~acc_hi + WIDTH'(1)) : acc_hi;
        if (is_div_q) begin
            res_hi = rem_s;
            res_lo = div0_q ? '1 : quo_s;
        end else begin
            res_hi = prod_s[PW-1:WIDTH];
            res_lo = prod_s[WIDTH-1:0];
        end
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div_q),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .opnd   (opnd),
        .nxt_hi (step_hi),
        .nxt_lo (step_lo)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div_q  <= is_div_in;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        div0_q    <= is_div_in && (in2 == '0);
                        cnt       <= '0;
                        busy      <= 1'b1;
                        acc_hi    <= '0;
                        acc_lo    <= is_div_in ? mag1 : mag2;
                        opnd      <= is_div_in ? mag2 : mag1;
                        state     <= S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
                        // Preload the finished magnitudes and go straight to write-back
                        if (early) begin
                            acc_hi <= is_div_in ? mag1 : '0;
                            acc_lo <= is_div_in ? '1 : '0;
                            state  <= S_SIGN;
                        end
`endif
                    end else begin
                        if (wr_hi) hi <= wr_data;
                        if (wr_lo) lo <= wr_data;
                    end
                end
                S_CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(ITERS - 1)) state <= S_SIGN;
                end
                S_SIGN: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed cases plus randomized ops checked
// against a plain-arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned W = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         wr_hi;
    logic         wr_lo;
    logic [W-1:0] wr_data;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] sb[$];

    muldiv_unit #(.WIDTH(W), .ITERS(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .in1     (in1),
        .in2     (in2),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: {hi, lo} from ordinary integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sbv;
        logic [63:0] r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (o)
            OP_MULT:  r = 64'(sa * sbv);
            OP_MULTU: r = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 0)            r = {a, 32'hFFFF_FFFF};
                else if (o == OP_DIV)  r = {32'(sa % sbv), 32'(sa / sbv)};
                else                   r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic short_op;
        short_op = o[1] ? (b == 0) : ((a == 0) || (b == 0));
        return (EARLY && short_op) ? 1 : W + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse consumes exactly one expected result
    initial begin
        forever begin
            @(negedge clock);
            if (reset !== 1'b1 && done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL result: unexpected done with hi=%h lo=%h, expected no completion", hi, lo);
                end else begin
                    chk("result", {hi, lo}, sb.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        @(negedge clock);
        op = o; in1 = a; in2 = b; start = 1'b1;
        sb.push_back(exp);
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done and cycles with busy high, from the current sample point
    task automatic wait_done(input int el);
        int lat;
        int bc;
        lat = 0;
        bc  = 0;
        if (busy) bc++;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
            if (busy) bc++;
        end
        chk("latency", 64'(lat), 64'(el));
        chk("busy_cycles", 64'(bc), 64'(el));
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        issue(o, a, b, exp);
        wait_done(exp_lat(o, a, b));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'd0; in1 = '0; in2 = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_hilo", {hi, lo}, 64'h0);
        chk("reset_busy_done", 64'({busy, done}), 64'h0);
        reset = 1'b0;

        run(OP_MULT,  32'hFFFF_FFFD, 32'd7,        {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
        run(OP_DIV,   32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run(OP_DIVU,  32'd7,         32'd2,        {32'd1, 32'd3});
        run(OP_DIV,   32'd5,         32'd0,        {32'd5, 32'hFFFF_FFFF});
        run(OP_DIV,   32'hFFFF_FFF9, 32'd0,        {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        run(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
        run(OP_MULT,  32'd0,         32'd5,        64'h0);

        // MTHI alone, then MTHI+MTLO together
        @(negedge clock);
        wr_hi = 1'b1; wr_data = 32'hA5A5_A5A5;
        @(negedge clock);
        wr_hi = 1'b0;
        chk("mthi", {hi, lo}, {32'hA5A5_A5A5, 32'h0});
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h3C3C_3C3C;
        @(negedge clock);
        wr_hi = 1'b0; wr_lo = 1'b0;
        chk("mthi_mtlo", {hi, lo}, {32'h3C3C_3C3C, 32'h3C3C_3C3C});

        // start with writes in the same cycle, then writes and start while busy
        @(negedge clock);
        op = OP_MULTU; in1 = 32'd6; in2 = 32'd7; start = 1'b1;
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF;
        sb.push_back({32'd0, 32'd42});
        @(posedge clock);
        #1;
        wr_data = 32'h1111_1111; in1 = 32'd9; in2 = 32'd9;
        repeat (5) @(posedge clock);
        #1;
        chk("hold_in_calc", {hi, lo}, {32'h3C3C_3C3C, 32'h3C3C_3C3C});
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        wait_done(W + 1 - 5);

        // Reset while counter is at 10 aborts the op and clears HI/LO
        issue(OP_MULT, 32'd12345, 32'd678, model(OP_MULT, 32'd12345, 32'd678));
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        void'(sb.pop_back());
        chk("abort_busy_done", 64'({busy, done}), 64'h0);
        chk("abort_hilo", {hi, lo}, 64'h0);
        run(OP_MULT, 32'd6, 32'd7, {32'd0, 32'd42});

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            run(o, a, b, model(o, a, b));
        end

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
